// File: rtl/pgm_palette.sv
// PGM palette: dual-port colour RAM with 68000 bus access and a 3-stage
// index-to-RGB video pipeline with delay-matched sync and blank.
module pgm_palette #(
    parameter int unsigned NUM_ENTRIES = 2304,
    parameter int unsigned IDX_W       = 12
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cpu_sel,
    input  logic             cpu_rnw,
    input  logic [IDX_W-1:0] cpu_addr,
    input  logic [15:0]      cpu_din,
    input  logic             cpu_uds_n,
    input  logic             cpu_lds_n,
    output logic [15:0]      cpu_dout,
    output logic             cpu_dtack_n,
    input  logic [IDX_W-1:0] pix_idx,
    input  logic             pix_hs,
    input  logic             pix_vs,
    input  logic             pix_blank_n,
    output logic [7:0]       r,
    output logic [7:0]       g,
    output logic [7:0]       b,
    output logic             hs,
    output logic             vs,
    output logic             blank_n
);

    localparam int unsigned   DATA_W = 16;
    localparam logic [IDX_W:0] LIMIT = (IDX_W+1)'(NUM_ENTRIES);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_WAIT   = 2'd2;
    localparam logic [1:0] S_ACK    = 2'd3;

    logic [DATA_W-1:0] mem [NUM_ENTRIES];

    // CPU-side registers
    logic [1:0]        state_q, state_d;
    logic [IDX_W-1:0]  a_addr_q, a_addr_d;
    logic              a_rnw_q, a_rnw_d;
    logic [DATA_W-1:0] a_din_q, a_din_d;
    logic              a_uds_n_q, a_uds_n_d;
    logic              a_lds_n_q, a_lds_n_d;
    logic              a_oor_q, a_oor_d;
    logic [DATA_W-1:0] dout_q, dout_d;
    logic              dtack_n_q, dtack_n_d;
    logic [DATA_W-1:0] a_rdata_q;
    logic              a_we_hi, a_we_lo;

    // Video-side registers
    logic [IDX_W-1:0]  s1_idx_q;
    logic              s1_oor_q, s1_hs_q, s1_vs_q, s1_blank_n_q;
    logic              s2_oor_q, s2_hs_q, s2_vs_q, s2_blank_n_q;
    logic [14:0]       b_rdata_q;
    logic [7:0]        r_q, g_q, b_q, r_d, g_d, b_d;
    logic              hs_q, vs_q, blank_n_q;

    // CPU FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            a_addr_q  <= '0;
            a_rnw_q   <= 1'b1;
            a_din_q   <= '0;
            a_uds_n_q <= 1'b1;
            a_lds_n_q <= 1'b1;
            a_oor_q   <= 1'b0;
            dout_q    <= '0;
            dtack_n_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            a_addr_q  <= a_addr_d;
            a_rnw_q   <= a_rnw_d;
            a_din_q   <= a_din_d;
            a_uds_n_q <= a_uds_n_d;
            a_lds_n_q <= a_lds_n_d;
            a_oor_q   <= a_oor_d;
            dout_q    <= dout_d;
            dtack_n_q <= dtack_n_d;
        end
    end

    // CPU FSM next state; dtack is low exactly while in ACK
    always_comb begin
        state_d   = state_q;
        a_addr_d  = a_addr_q;
        a_rnw_d   = a_rnw_q;
        a_din_d   = a_din_q;
        a_uds_n_d = a_uds_n_q;
        a_lds_n_d = a_lds_n_q;
        a_oor_d   = a_oor_q;
        dout_d    = dout_q;
        dtack_n_d = dtack_n_q;
        case (state_q)
            S_IDLE: begin
                dtack_n_d = 1'b1;
                if (cpu_sel) begin
                    a_addr_d  = cpu_addr;
                    a_rnw_d   = cpu_rnw;
                    a_din_d   = cpu_din;
                    a_uds_n_d = cpu_uds_n;
                    a_lds_n_d = cpu_lds_n;
                    a_oor_d   = {1'b0, cpu_addr} >= LIMIT;
                    state_d   = S_ACCESS;
                end
            end
            S_ACCESS: begin
                state_d = cpu_sel ? S_WAIT : S_IDLE;
            end
            S_WAIT: begin
                if (a_rnw_q) begin
                    dout_d = a_oor_q ? '0 : a_rdata_q;
                end
                if (cpu_sel) begin
                    state_d   = S_ACK;
                    dtack_n_d = 1'b0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                if (!cpu_sel) begin
                    state_d   = S_IDLE;
                    dtack_n_d = 1'b1;
                end
            end
        endcase
    end

    // The write is committed in ACCESS even if the cycle is being aborted
    assign a_we_hi = (state_q == S_ACCESS) && !a_rnw_q && !a_oor_q && !a_uds_n_q;
    assign a_we_lo = (state_q == S_ACCESS) && !a_rnw_q && !a_oor_q && !a_lds_n_q;

    // Port A: CPU, byte-enabled write, registered read
    always_ff @(posedge clk) begin
        if (a_we_hi) begin
            mem[a_addr_q][15:8] <= a_din_q[15:8];
        end
        if (a_we_lo) begin
            mem[a_addr_q][7:0] <= a_din_q[7:0];
        end
        if (!a_oor_q) begin
            a_rdata_q <= mem[a_addr_q];
        end
    end

    // Port B: video read; returns pre-write data on a same-edge collision
    always_ff @(posedge clk) begin
        if (!s1_oor_q) begin
            b_rdata_q <= mem[s1_idx_q][14:0];
        end
    end

    // 5-to-8 bit expansion by replicating the top bits
    always_comb begin
        r_d = '0;
        g_d = '0;
        b_d = '0;
        if (s2_blank_n_q && !s2_oor_q) begin
            r_d = {b_rdata_q[14:10], b_rdata_q[14:12]};
            g_d = {b_rdata_q[9:5],   b_rdata_q[9:7]};
            b_d = {b_rdata_q[4:0],   b_rdata_q[4:2]};
        end
    end

    // Video pipeline: index/sync capture, RAM read, colour output
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_idx_q     <= '0;
            s1_oor_q     <= 1'b0;
            s1_hs_q      <= 1'b0;
            s1_vs_q      <= 1'b0;
            s1_blank_n_q <= 1'b0;
            s2_oor_q     <= 1'b0;
            s2_hs_q      <= 1'b0;
            s2_vs_q      <= 1'b0;
            s2_blank_n_q <= 1'b0;
            r_q          <= '0;
            g_q          <= '0;
            b_q          <= '0;
            hs_q         <= 1'b0;
            vs_q         <= 1'b0;
            blank_n_q    <= 1'b0;
        end else begin
            s1_idx_q     <= pix_idx;
            s1_oor_q     <= {1'b0, pix_idx} >= LIMIT;
            s1_hs_q      <= pix_hs;
            s1_vs_q      <= pix_vs;
            s1_blank_n_q <= pix_blank_n;
            s2_oor_q     <= s1_oor_q;
            s2_hs_q      <= s1_hs_q;
            s2_vs_q      <= s1_vs_q;
            s2_blank_n_q <= s1_blank_n_q;
            r_q          <= r_d;
            g_q          <= g_d;
            b_q          <= b_d;
            hs_q         <= s2_hs_q;
            vs_q         <= s2_vs_q;
            blank_n_q    <= s2_blank_n_q;
        end
    end

    assign cpu_dout    = dout_q;
    assign cpu_dtack_n = dtack_n_q;
    assign r           = r_q;
    assign g           = g_q;
    assign b           = b_q;
    assign hs          = hs_q;
    assign vs          = vs_q;
    assign blank_n     = blank_n_q;

endmodule

// File: tb/tb_pgm_palette.sv
// Randomized bench for pgm_palette: shadow-memory model of the palette,
// 3-clock video delay model and CPU handshake timing checks.
module tb_pgm_palette;

    localparam int NUM = 2304;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_sel, cpu_rnw, cpu_uds_n, cpu_lds_n;
    logic [11:0] cpu_addr;
    logic [15:0] cpu_din, cpu_dout;
    logic        cpu_dtack_n;
    logic [11:0] pix_idx;
    logic        pix_hs, pix_vs, pix_blank_n;
    logic [7:0]  r, g, b;
    logic        hs, vs, blank_n;

    pgm_palette dut (
        .clk(clk), .reset(reset),
        .cpu_sel(cpu_sel), .cpu_rnw(cpu_rnw), .cpu_addr(cpu_addr), .cpu_din(cpu_din),
        .cpu_uds_n(cpu_uds_n), .cpu_lds_n(cpu_lds_n),
        .cpu_dout(cpu_dout), .cpu_dtack_n(cpu_dtack_n),
        .pix_idx(pix_idx), .pix_hs(pix_hs), .pix_vs(pix_vs), .pix_blank_n(pix_blank_n),
        .r(r), .g(g), .b(b), .hs(hs), .vs(vs), .blank_n(blank_n)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    logic [15:0] shadow [NUM];
    bit          known  [NUM];
    logic [11:0] v_idx [8];
    bit          v_hs [8], v_vs [8], v_bl [8], v_ok [8];
    logic [15:0] v_rd [8];
    int          cyc = 8;
    int          force_idx = -1;
    int          force_blank = -1;
    logic [11:0] cur_addr = '0;
    bit          wr_pend = 0;
    logic [11:0] wr_addr;
    logic [15:0] wr_data;
    bit          wr_hi, wr_lo;
    logic [15:0] last_dout = '0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [23:0] expand(input logic [15:0] w);
        int r5, g5, b5;
        r5 = (int'(w) >> 10) & 31;
        g5 = (int'(w) >> 5) & 31;
        b5 = int'(w) & 31;
        return {8'(r5 * 8 + r5 / 4), 8'(g5 * 8 + g5 / 4), 8'(b5 * 8 + b5 / 4)};
    endfunction

    // One clock: drive next pixel, advance, update model, check video outputs
    task automatic tick();
        int n, e1, e2;
        logic [11:0] idx;
        logic [23:0] exp_rgb;
        bit rst_now;
        n = cyc + 1;
        if (force_idx >= 0) idx = 12'(force_idx);
        else begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3: idx = 12'($urandom_range(0, 255));
                4, 5, 6:    idx = 12'(12'h800 + $urandom_range(0, 255));
                7:          idx = 12'($urandom_range(12'h900, 12'hFFF));
                8:          idx = 12'h8FF;
                default:    idx = cur_addr;
            endcase
        end
        v_idx[n % 8] = idx;
        v_hs[n % 8]  = 1'($urandom_range(0, 1));
        v_vs[n % 8]  = 1'($urandom_range(0, 1));
        v_bl[n % 8]  = (force_blank >= 0) ? 1'(force_blank) : ($urandom_range(0, 3) != 0);
        pix_idx     = idx;
        pix_hs      = v_hs[n % 8];
        pix_vs      = v_vs[n % 8];
        pix_blank_n = v_bl[n % 8];
        rst_now     = reset;
        @(posedge clk);
        cyc = n;
        // pixel sampled one edge ago reads the palette at this edge, before any write lands
        e1 = (cyc - 1) % 8;
        if (int'(v_idx[e1]) < NUM) begin
            v_rd[e1] = shadow[v_idx[e1]];
            v_ok[e1] = !v_bl[e1] || known[v_idx[e1]];
        end else begin
            v_rd[e1] = '0;
            v_ok[e1] = 1'b1;
        end
        if (wr_pend) begin
            if (int'(wr_addr) < NUM) begin
                if (wr_hi) shadow[wr_addr][15:8] = wr_data[15:8];
                if (wr_lo) shadow[wr_addr][7:0]  = wr_data[7:0];
                if (wr_hi && wr_lo) known[wr_addr] = 1'b1;
            end
            wr_pend = 0;
        end
        if (rst_now) begin
            for (int k = 0; k < 3; k++) begin
                v_hs[(cyc - k) % 8] = 0;
                v_vs[(cyc - k) % 8] = 0;
                v_bl[(cyc - k) % 8] = 0;
                v_ok[(cyc - k) % 8] = 1;
            end
        end
        #1;
        e2 = (cyc - 2) % 8;
        if (v_ok[e2]) begin
            exp_rgb = (!v_bl[e2] || int'(v_idx[e2]) >= NUM) ? 24'h0 : expand(v_rd[e2]);
            check_eq("vid_r", 32'(r), 32'(exp_rgb[23:16]));
            check_eq("vid_g", 32'(g), 32'(exp_rgb[15:8]));
            check_eq("vid_b", 32'(b), 32'(exp_rgb[7:0]));
        end
        check_eq("vid_hs", 32'(hs), 32'(v_hs[e2]));
        check_eq("vid_vs", 32'(vs), 32'(v_vs[e2]));
        check_eq("vid_blank_n", 32'(blank_n), 32'(v_bl[e2]));
    endtask

    // One bus cycle; abort_at 1 drops sel in ACCESS, 2 drops it in WAIT
    task automatic cpu_op(input logic rnw, input logic [11:0] addr, input logic [15:0] din,
                          input logic uds_n, input logic lds_n, input int abort_at,
                          output logic [15:0] rdata);
        logic [15:0] exp_rd;
        int hold;
        rdata    = '0;
        cpu_sel  = 1'b1;
        cpu_rnw  = rnw;
        cpu_addr = addr;
        cpu_din  = din;
        cpu_uds_n = uds_n;
        cpu_lds_n = lds_n;
        cur_addr = addr;
        exp_rd   = (int'(addr) < NUM) ? shadow[addr] : 16'h0000;
        tick();
        check_eq("dtack_e0", 32'(cpu_dtack_n), 32'd1);
        if (!rnw) begin
            wr_pend = 1; wr_addr = addr; wr_data = din; wr_hi = !uds_n; wr_lo = !lds_n;
        end
        if (abort_at == 1) cpu_sel = 1'b0;
        tick();
        check_eq("dtack_e1", 32'(cpu_dtack_n), 32'd1);
        if (abort_at == 1) begin
            tick();
            check_eq("dtack_abort_acc", 32'(cpu_dtack_n), 32'd1);
            return;
        end
        if (abort_at == 2) cpu_sel = 1'b0;
        tick();
        if (abort_at == 2) begin
            if (rnw) last_dout = exp_rd;
            check_eq("dtack_abort_wait", 32'(cpu_dtack_n), 32'd1);
            tick();
            check_eq("dtack_abort_wait2", 32'(cpu_dtack_n), 32'd1);
            return;
        end
        check_eq("dtack_e2", 32'(cpu_dtack_n), 32'd0);
        if (rnw) last_dout = exp_rd;
        check_eq(rnw ? "cpu_rd" : "cpu_dout_keep", 32'(cpu_dout), 32'(last_dout));
        rdata = cpu_dout;
        hold = $urandom_range(0, 2);
        repeat (hold) begin
            tick();
            check_eq("dtack_hold", 32'(cpu_dtack_n), 32'd0);
        end
        cpu_sel = 1'b0;
        tick();
        check_eq("dtack_release", 32'(cpu_dtack_n), 32'd1);
    endtask

    initial begin
        logic [15:0] rd;
        logic [11:0] a;
        int k;
        for (int i = 0; i < 8; i++) begin
            v_idx[i] = '0; v_hs[i] = 0; v_vs[i] = 0; v_bl[i] = 0; v_ok[i] = 1; v_rd[i] = '0;
        end
        for (int i = 0; i < NUM; i++) begin
            shadow[i] = '0; known[i] = 0;
        end
        reset = 1'b1; cpu_sel = 1'b0; cpu_rnw = 1'b1; cpu_addr = '0; cpu_din = '0;
        cpu_uds_n = 1'b1; cpu_lds_n = 1'b1;
        pix_idx = '0; pix_hs = 1'b0; pix_vs = 1'b0; pix_blank_n = 1'b0;
        repeat (4) tick();
        check_eq("rst_dtack", 32'(cpu_dtack_n), 32'd1);
        check_eq("rst_dout", 32'(cpu_dout), 32'd0);
        reset = 1'b0;

        // Fill the two palette windows used by the video stimulus
        for (int i = 0; i < 512; i++) begin
            a = (i < 256) ? 12'(i) : 12'(12'h800 + i - 256);
            cpu_op(1'b0, a, 16'($urandom), 1'b0, 1'b0, 0, rd);
        end

        // White entry at 0, shown on index 0
        cpu_op(1'b0, 12'h000, 16'h7FFF, 1'b0, 1'b0, 0, rd);
        force_idx = 0; force_blank = 1;
        repeat (3) tick();
        check_eq("white_r", 32'(r), 32'hFF);
        check_eq("white_g", 32'(g), 32'hFF);
        check_eq("white_b", 32'(b), 32'hFF);
        force_idx = -1; force_blank = -1;

        // Pure red at 0x123
        cpu_op(1'b0, 12'h123, 16'h7C00, 1'b0, 1'b0, 0, rd);
        cpu_op(1'b1, 12'h123, 16'h0000, 1'b0, 1'b0, 0, rd);
        check_eq("red_rd", 32'(rd), 32'h7C00);
        force_idx = 12'h123; force_blank = 1;
        repeat (3) tick();
        check_eq("red_r", 32'(r), 32'hFF);
        check_eq("red_g", 32'(g), 32'h00);
        check_eq("red_b", 32'(b), 32'h00);
        force_idx = -1; force_blank = -1;

        // Byte lanes
        cpu_op(1'b0, 12'h010, 16'h1234, 1'b0, 1'b0, 0, rd);
        cpu_op(1'b0, 12'h010, 16'hABCD, 1'b0, 1'b1, 0, rd);
        cpu_op(1'b1, 12'h010, 16'h0000, 1'b0, 1'b0, 0, rd);
        check_eq("byte_upper", 32'(rd), 32'hAB34);
        cpu_op(1'b0, 12'h010, 16'hABCD, 1'b1, 1'b0, 0, rd);
        cpu_op(1'b1, 12'h010, 16'h0000, 1'b0, 1'b0, 0, rd);
        check_eq("byte_lower", 32'(rd), 32'hABCD);
        cpu_op(1'b0, 12'h010, 16'h0000, 1'b1, 1'b1, 0, rd);
        cpu_op(1'b1, 12'h010, 16'h0000, 1'b0, 1'b0, 0, rd);
        check_eq("byte_none", 32'(rd), 32'hABCD);

        // Out of range
        cpu_op(1'b0, 12'h900, 16'h7FFF, 1'b0, 1'b0, 0, rd);
        cpu_op(1'b1, 12'h900, 16'h0000, 1'b0, 1'b0, 0, rd);
        check_eq("oor_rd", 32'(rd), 32'h0000);
        force_idx = 12'h900; force_blank = 1;
        repeat (4) tick();
        check_eq("oor_rgb", 32'({r, g, b}), 32'h0);
        force_idx = 12'h8FF;
        repeat (4) tick();
        force_idx = -1; force_blank = -1;

        // Blanked white entry: sync passes, colour stays zero
        force_idx = 0; force_blank = 0;
        repeat (12) tick();
        force_idx = -1; force_blank = -1;

        // Collision: write while video reads the same entry
        force_idx = 12'h050; force_blank = 1;
        cpu_op(1'b0, 12'h050, 16'h03E0, 1'b0, 1'b0, 0, rd);
        repeat (3) tick();
        check_eq("collide_g", 32'(g), 32'hFF);
        force_idx = -1; force_blank = -1;

        // Aborts: the write still lands, the next access acks normally
        cpu_op(1'b0, 12'h020, 16'h5555, 1'b0, 1'b0, 2, rd);
        cpu_op(1'b1, 12'h020, 16'h0000, 1'b0, 1'b0, 0, rd);
        check_eq("abort_wait_wr", 32'(rd), 32'h5555);
        cpu_op(1'b0, 12'h021, 16'h6666, 1'b0, 1'b0, 1, rd);
        cpu_op(1'b1, 12'h021, 16'h0000, 1'b0, 1'b0, 0, rd);
        check_eq("abort_acc_wr", 32'(rd), 32'h6666);

        // Reset while in ACK
        cpu_sel = 1'b1; cpu_rnw = 1'b1; cpu_addr = 12'h123; cur_addr = 12'h123;
        repeat (3) tick();
        check_eq("pre_rst_ack", 32'(cpu_dtack_n), 32'd0);
        reset = 1'b1; cpu_sel = 1'b0;
        tick();
        check_eq("midrst_dtack", 32'(cpu_dtack_n), 32'd1);
        check_eq("midrst_dout", 32'(cpu_dout), 32'd0);
        check_eq("midrst_rgb", 32'({r, g, b}), 32'h0);
        reset = 1'b0; last_dout = '0;
        tick();
        cpu_op(1'b1, 12'h123, 16'h0000, 1'b0, 1'b0, 0, rd);
        check_eq("post_rst_rd", 32'(rd), 32'h7C00);

        // Random bus traffic against random video
        for (int i = 0; i < 400; i++) begin
            k = $urandom_range(0, 9);
            if (k < 4)      a = 12'($urandom_range(0, 255));
            else if (k < 8) a = 12'(12'h800 + $urandom_range(0, 255));
            else            a = 12'($urandom_range(12'h900, 12'hFFF));
            k = $urandom_range(0, 3);
            cpu_op(1'($urandom_range(0, 1)), a, 16'($urandom), 1'(k == 2 || k == 3),
                   1'(k == 1 || k == 3),
                   ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 2)) : 0, rd);
            if ($urandom_range(0, 3) == 0) tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
